// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow signal in clk_in cycles.
// The slow input is synchronized, edge-detected, and timed by a small FSM that
// can run single-shot or back-to-back, with a sticky timeout error flag.
module period_meter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 100000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    // Last legal counter value; reaching it without an edge aborts the run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       period_next;
    logic [CNT_W-1:0]       high_time_next;
    logic                   valid_next;
    logic                   busy_next;
    logic                   timeout_err_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   prev;
    logic                   rise;
    logic                   fall;
    logic                   at_limit;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~prev;
    assign fall     = ~s & prev;
    assign cnt_inc  = cnt + CNT_ONE;
    assign at_limit = (cnt == CNT_LAST);

    // Synchronizer chain and one-cycle edge history for the async input.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev   <= s;
        end
    end

    // State, counter and registered result outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= CNT_ZERO;
            period      <= CNT_ZERO;
            high_time   <= CNT_ZERO;
            valid       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            period      <= period_next;
            high_time   <= high_time_next;
            valid       <= valid_next;
            busy        <= busy_next;
            timeout_err <= timeout_err_next;
        end
    end

    // Next-state logic; edges take priority over the timeout in the same cycle.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        period_next      = period;
        high_time_next   = high_time;
        valid_next       = 1'b0;
        timeout_err_next = timeout_err;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next       = ARM;
                    cnt_next         = CNT_ZERO;
                    timeout_err_next = 1'b0;
                end
            end
            ARM: begin
                cnt_next = cnt_inc;
                if (rise) begin
                    state_next = MEAS_HIGH;
                    cnt_next   = CNT_ONE;
                end else if (at_limit) begin
                    state_next       = IDLE;
                    cnt_next         = cnt;
                    timeout_err_next = 1'b1;
                end
            end
            MEAS_HIGH: begin
                cnt_next = cnt_inc;
                if (fall) begin
                    state_next     = MEAS_LOW;
                    high_time_next = cnt;
                end else if (at_limit) begin
                    state_next       = IDLE;
                    cnt_next         = cnt;
                    timeout_err_next = 1'b1;
                end
            end
            MEAS_LOW: begin
                cnt_next = cnt_inc;
                if (rise) begin
                    period_next = cnt;
                    valid_next  = 1'b1;
                    if (cont) begin
                        // Closing rise opens the next period.
                        state_next = MEAS_HIGH;
                        cnt_next   = CNT_ONE;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = cnt;
                    end
                end else if (at_limit) begin
                    state_next       = IDLE;
                    cnt_next         = cnt;
                    timeout_err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: scoreboard of expected results,
// one task per scenario, summary line at the end.
module tb_period_meter;

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned TIMEOUT     = 50;
    localparam int unsigned SYNC_STAGES = 2;

    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
    } exp_t;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             sig_in = 1'b0;
    logic             start  = 1'b0;
    logic             cont   = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             busy;
    logic             timeout_err;

    int   n_cmp   = 0;
    int   n_bad   = 0;
    exp_t sb[$];
    bit   div_en  = 1'b0;
    int   div_cnt = 0;
    int   lat_ref = -1;

    period_meter #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .start      (start),
        .cont       (cont),
        .period     (period),
        .high_time  (high_time),
        .valid      (valid),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk_in = ~clk_in;

    // Divide-by-10 reference wave (5 high, 5 low), updated on the falling edge.
    initial forever begin
        @(negedge clk_in);
        if (div_en) begin
            sig_in  = (div_cnt < 5);
            div_cnt = (div_cnt == 9) ? 0 : div_cnt + 1;
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic div_off();
        div_en = 1'b0;
        sig_in = 1'b0;
        repeat (6) step();
    endtask

    task automatic div_on();
        div_cnt = 0;
        div_en  = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_cmp++; if (period !== '0) begin n_bad++; $display("FAIL reset_period got %0d want 0", period); end
        n_cmp++; if (high_time !== '0) begin n_bad++; $display("FAIL reset_high got %0d want 0", high_time); end
        n_cmp++; if ({valid, busy, timeout_err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got v/b/e=%b want 000", {valid, busy, timeout_err});
        end
        rst = 1'b0;
        repeat (4) step();
        n_cmp++; if ({valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL post_reset_idle got v/b=%b want 00", {valid, busy});
        end
    endtask

    // One divider measurement, cont=0; poke=1 re-issues start while busy.
    task automatic test_single(input string tag, input bit poke);
        exp_t e;
        bit   got = 1'b0;
        int   lat = 0;
        int   extra = 0;
        cont = 1'b0;
        div_off();
        div_on();
        repeat (3) step();
        sb.push_back(exp_t'{per: CNT_W'(10), hi: CNT_W'(5)});
        pulse_start();
        for (int c = 0; c < 80 && !got; c++) begin
            step();
            start = poke && (c == 4 || c == 15);
            if (valid === 1'b1) begin
                got = 1'b1;
                lat = c;
                e   = sb.pop_front();
                n_cmp++; if (period !== e.per) begin n_bad++; $display("FAIL %s_period got %0d want %0d", tag, period, e.per); end
                n_cmp++; if (high_time !== e.hi) begin n_bad++; $display("FAIL %s_high got %0d want %0d", tag, high_time, e.hi); end
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_at_valid got %b want 0", tag, busy); end
            end
        end
        start = 1'b0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_no_valid got none want 1 pulse within 80 cycles", tag);
            sb.delete();
        end else if (!poke) begin
            lat_ref = lat;
        end else begin
            n_cmp++; if (lat !== lat_ref) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", tag, lat, lat_ref); end
        end
        repeat (40) begin
            step();
            if (valid === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL %s_extra_valid got %0d want 0", tag, extra); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_after got %b want 0", tag, busy); end
    endtask

    // Continuous mode: pulses every 10 cycles; dropping cont ends after the current period.
    task automatic test_cont();
        exp_t e;
        int   pulses = 0;
        int   last_c = 0;
        int   extra  = 0;
        div_off();
        div_on();
        repeat (3) step();
        cont = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back(exp_t'{per: CNT_W'(10), hi: CNT_W'(5)});
        pulse_start();
        for (int c = 0; c < 200 && pulses < 5; c++) begin
            step();
            if (valid === 1'b1) begin
                pulses++;
                e = sb.pop_front();
                n_cmp++; if (period !== e.per) begin n_bad++; $display("FAIL cont_period#%0d got %0d want %0d", pulses, period, e.per); end
                n_cmp++; if (high_time !== e.hi) begin n_bad++; $display("FAIL cont_high#%0d got %0d want %0d", pulses, high_time, e.hi); end
                if (pulses > 1) begin
                    n_cmp++; if (c - last_c !== 10) begin n_bad++; $display("FAIL cont_spacing#%0d got %0d want 10", pulses, c - last_c); end
                end
                if (pulses == 4) cont = 1'b0;
                if (pulses == 5) begin
                    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_stop_busy got %b want 0", busy); end
                end
                last_c = c;
            end
        end
        cont = 1'b0;
        n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL cont_pulse_count got %0d want 5", pulses); end
        sb.delete();
        repeat (30) begin
            step();
            if (valid === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL cont_extra_valid got %0d want 0", extra); end
    endtask

    // sig_in stuck low: abort exactly TIMEOUT cycles after the start cycle.
    task automatic test_timeout();
        int vcount = 0;
        div_off();
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_busy_start got %b want 1", busy); end
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            step();
            if (valid === 1'b1) vcount++;
            if (k == int'(TIMEOUT) - 1) begin
                n_cmp++; if ({busy, timeout_err} !== 2'b10) begin
                    n_bad++; $display("FAIL to_before got b/e=%b want 10", {busy, timeout_err});
                end
            end
        end
        n_cmp++; if ({busy, timeout_err} !== 2'b01) begin
            n_bad++; $display("FAIL to_at_limit got b/e=%b want 01", {busy, timeout_err});
        end
        n_cmp++; if (period !== CNT_W'(10) || high_time !== CNT_W'(5)) begin
            n_bad++; $display("FAIL to_hold got %0d/%0d want 10/5", period, high_time);
        end
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL to_valid got %0d want 0", vcount); end
        pulse_start();
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_clear got %b want 0", timeout_err); end
        repeat (int'(TIMEOUT) + 5) step();
    endtask

    // Asynchronous 3-high/7-low wave with +/-4 time units of jitter per edge.
    task automatic test_jitter();
        int pulses = 0;
        for (int i = 0; i < 11; i++) sb.push_back(exp_t'{per: CNT_W'(10), hi: CNT_W'(3)});
        cont = 1'b1;
        pulse_start();
        fork
            begin
                longint base;
                longint t;
                @(negedge clk_in);
                base = longint'($time) + 20;
                for (int p = 0; p < 12; p++) begin
                    t = base + 100 * p + longint'($urandom_range(8)) - 4;
                    #(t - longint'($time)) sig_in = 1'b1;
                    t = base + 100 * p + 30 + longint'($urandom_range(8)) - 4;
                    #(t - longint'($time)) sig_in = 1'b0;
                    if (p == 10) cont = 1'b0;
                end
            end
            begin
                exp_t e;
                for (int c = 0; c < 200; c++) begin
                    step();
                    if (valid === 1'b1) begin
                        pulses++;
                        if (sb.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL jit_spurious got pulse #%0d want at most 11", pulses);
                        end else begin
                            e = sb.pop_front();
                            n_cmp++; if (period + 1 < e.per || period > e.per + 1) begin
                                n_bad++; $display("FAIL jit_period#%0d got %0d want %0d+-1", pulses, period, e.per);
                            end
                            n_cmp++; if (high_time + 1 < e.hi || high_time > e.hi + 1) begin
                                n_bad++; $display("FAIL jit_high#%0d got %0d want %0d+-1", pulses, high_time, e.hi);
                            end
                        end
                    end
                end
            end
        join
        cont = 1'b0;
        n_cmp++; if (pulses !== 11) begin n_bad++; $display("FAIL jit_count got %0d want 11", pulses); end
        n_cmp++; if ({busy, timeout_err} !== 2'b00) begin
            n_bad++; $display("FAIL jit_end got b/e=%b want 00", {busy, timeout_err});
        end
        sb.delete();
    endtask

    // Reset while in MEAS_LOW, then a clean measurement afterwards.
    task automatic test_reset_mid();
        int vcount = 0;
        div_off();
        cont = 1'b0;
        pulse_start();
        repeat (2) step();
        sig_in = 1'b1;
        repeat (8) step();
        sig_in = 1'b0;
        repeat (6) step();
        n_cmp++; if (high_time !== CNT_W'(8)) begin n_bad++; $display("FAIL mid_high got %0d want 8", high_time); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (period !== '0 || high_time !== '0) begin
            n_bad++; $display("FAIL mid_rst_data got %0d/%0d want 0/0", period, high_time);
        end
        n_cmp++; if ({valid, busy, timeout_err} !== 3'b000) begin
            n_bad++; $display("FAIL mid_rst_flags got %b want 000", {valid, busy, timeout_err});
        end
        step();
        rst = 1'b0;
        repeat (20) begin
            step();
            if (valid === 1'b1) vcount++;
        end
        n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL mid_valid got %0d want 0", vcount); end
        test_single("after_rst", 1'b0);
    endtask

    initial begin
        test_reset();
        test_single("single", 1'b0);
        test_cont();
        test_timeout();
        test_jitter();
        test_reset_mid();
        test_single("busy_start", 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
